// File: rtl/axil_cfg_master_pkg.sv
// Shared types and constants for the AXI4-Lite configuration master.
// Holds FSM encodings, AXI response codes, fixed channel attributes and the default timeout.
package axil_cfg_master_pkg;

    // Default abort limit, in cycles, for one outstanding transaction.
    localparam int unsigned TIMEOUT_DEFAULT = 256;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access on every request.
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // Configuration registers are always written as full words.
    localparam logic [3:0] WSTRB_FULL = 4'hF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_e;

    // Command fields held for the life of a transaction.
    // The read/write direction is carried by the FSM state itself.
    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    // Anything other than OKAY is reported as an error to the requester.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_cfg_master_timeout.sv
// Saturating cycle counter that flags when a transaction has run too long.
// Ports: clk, rst (async high), clear (restart), enable (count), expire (limit reached while enabled).
module axil_timeout_cnt
    import axil_cfg_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturate at LAST so that a handshake which wins against an expiry
    // leaves the limit still reached for the next phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite master that turns simple register commands into AXI transactions.
// Ports: cmd_* (command in), rsp_* (response out), M_AXI_* (AXI4-Lite master), clk, rst (async high).
module axil_cfg_master
    import axil_cfg_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [5:0]  M_AXI_AWADDR,
    output logic [2:0]  M_AXI_AWPROT,

    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,

    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    input  logic [1:0]  M_AXI_BRESP,

    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    output logic [5:0]  M_AXI_ARADDR,
    output logic [2:0]  M_AXI_ARPROT,

    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP
);

    state_e state, state_d;
    cmd_t   cmd_q, cmd_d;
    rsp_t   rsp_q, rsp_d;
    logic   aw_done, aw_done_d;
    logic   w_done, w_done_d;

    logic   cnt_clear;
    logic   cnt_enable;
    logic   expire;

    logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Every AXI-side output is a decode of registered state, so no
    // command input reaches the bus combinationally.
    assign M_AXI_AWVALID = (state == WR_REQ) && !aw_done;
    assign M_AXI_WVALID  = (state == WR_REQ) && !w_done;
    assign M_AXI_BREADY  = (state == WR_RESP);
    assign M_AXI_ARVALID = (state == RD_REQ);
    assign M_AXI_RREADY  = (state == RD_DATA);

    assign M_AXI_AWADDR  = cmd_q.addr;
    assign M_AXI_ARADDR  = cmd_q.addr;
    assign M_AXI_WDATA   = cmd_q.wdata;
    assign M_AXI_AWPROT  = PROT_DEFAULT;
    assign M_AXI_ARPROT  = PROT_DEFAULT;
    assign M_AXI_WSTRB   = WSTRB_FULL;

    // Held low while rst is asserted so the requester sees no
    // acceptance window until reset is released.
    assign cmd_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RSP);
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RVALID  && M_AXI_RREADY;

    assign cnt_enable = (state == WR_REQ)  || (state == WR_RESP) ||
                        (state == RD_REQ)  || (state == RD_DATA);

    axil_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cmd_q   <= '0;
            rsp_q   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_d;
            cmd_q   <= cmd_d;
            rsp_q   <= rsp_d;
            aw_done <= aw_done_d;
            w_done  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state;
        cmd_d     = cmd_q;
        rsp_d     = rsp_q;
        aw_done_d = aw_done;
        w_done_d  = w_done;
        cnt_clear = 1'b0;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d.addr  = cmd_addr;
                    cmd_d.wdata = cmd_wdata;
                    rsp_d       = '0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    cnt_clear   = 1'b1;
                    state_d     = cmd_wr ? WR_REQ : RD_REQ;
                end
            end

            WR_REQ: begin
                // AW and W complete independently; either order,
                // or both together, finishes the request phase.
                aw_done_d = aw_done || aw_hs;
                w_done_d  = w_done  || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end else if (expire && !aw_hs && !w_hs) begin
                    state_d     = RSP;
                    rsp_d.rdata = '0;
                    rsp_d.err   = 1'b1;
                end
            end

            WR_RESP: begin
                if (b_hs) begin
                    state_d     = RSP;
                    rsp_d.rdata = '0;
                    rsp_d.err   = resp_is_err(M_AXI_BRESP);
                end else if (expire) begin
                    state_d     = RSP;
                    rsp_d.rdata = '0;
                    rsp_d.err   = 1'b1;
                end
            end

            RD_REQ: begin
                if (ar_hs) begin
                    state_d = RD_DATA;
                end else if (expire) begin
                    state_d     = RSP;
                    rsp_d.rdata = '0;
                    rsp_d.err   = 1'b1;
                end
            end

            RD_DATA: begin
                if (r_hs) begin
                    state_d     = RSP;
                    rsp_d.rdata = M_AXI_RDATA;
                    rsp_d.err   = resp_is_err(M_AXI_RRESP);
                end else if (expire) begin
                    state_d     = RSP;
                    rsp_d.rdata = '0;
                    rsp_d.err   = 1'b1;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Self-checking bench for axil_cfg_master with a behavioural AXI4-Lite slave.
// Expected responses come from a word-array register model kept by the bench.
module tb_axil_cfg_master;

    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        awvalid, awready;
    logic [5:0]  awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [5:0]  araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int errors = 0;
    int checks = 0;

    int cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
    bit cfg_w_after_aw, cfg_ar_never;
    logic [1:0] cfg_bresp, cfg_rresp;

    logic [31:0] s_mem [16];
    logic [31:0] model_mem [16];

    bit got_aw, got_w, r_pend;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, scyc;
    int aw_hs_cyc, w_hs_cyc;
    logic p_awv, p_wv, p_bready, p_arv, p_rready;
    logic [5:0]  p_awaddr, p_araddr, cap_awaddr, cap_araddr;
    logic [2:0]  p_awprot, p_arprot, cap_awprot, cap_arprot;
    logic [31:0] p_wdata, cap_wdata;
    logic [3:0]  p_wstrb, cap_wstrb;
    bit weligible;

    always #5 clk = ~clk;

    axil_cfg_master dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_wr        (cmd_wr),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp)
    );

    // Behavioural slave, stepped once per falling edge. A handshake at the
    // rising edge is recognised from what was shown at the previous fall.
    initial begin : slave
        for (int i = 0; i < 16; i++) s_mem[i] = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        got_aw = 0; got_w = 0; r_pend = 0; scyc = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        p_awv = 0; p_wv = 0; p_bready = 0; p_arv = 0; p_rready = 0;
        forever begin
            @(negedge clk);
            scyc++;
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0;
                arready = 0; rvalid = 0;
                got_aw = 0; got_w = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                p_awv = 0; p_wv = 0; p_bready = 0; p_arv = 0; p_rready = 0;
            end else begin
                if (p_awv && awready) begin
                    got_aw = 1; cap_awaddr = p_awaddr;
                    cap_awprot = p_awprot; aw_hs_cyc = scyc;
                end
                if (p_wv && wready) begin
                    got_w = 1; cap_wdata = p_wdata;
                    cap_wstrb = p_wstrb; w_hs_cyc = scyc;
                end
                if (bvalid && p_bready) begin
                    bvalid = 0; got_aw = 0; got_w = 0; b_cnt = 0;
                end
                if (p_arv && arready) begin
                    r_pend = 1; r_cnt = 0;
                    cap_araddr = p_araddr; cap_arprot = p_arprot;
                end
                if (rvalid && p_rready) begin
                    rvalid = 0; rdata = 0;
                end

                awready = awvalid && (aw_cnt >= cfg_aw_dly);
                aw_cnt  = awvalid ? aw_cnt + 1 : 0;

                weligible = wvalid && (!cfg_w_after_aw || got_aw);
                wready = weligible && (w_cnt >= cfg_w_dly);
                w_cnt  = weligible ? w_cnt + 1 : 0;

                if (got_aw && got_w && !bvalid) begin
                    if (b_cnt >= cfg_b_dly) begin
                        bvalid = 1; bresp = cfg_bresp;
                        if (cfg_bresp == 2'b00) s_mem[cap_awaddr[5:2]] = cap_wdata;
                    end else begin
                        b_cnt++;
                    end
                end

                arready = arvalid && !cfg_ar_never && (ar_cnt >= cfg_ar_dly);
                ar_cnt  = arvalid ? ar_cnt + 1 : 0;

                if (r_pend && !rvalid) begin
                    if (r_cnt >= cfg_r_dly) begin
                        rvalid = 1; rresp = cfg_rresp;
                        rdata = s_mem[cap_araddr[5:2]]; r_pend = 0;
                    end else begin
                        r_cnt++;
                    end
                end

                p_awv = awvalid; p_awaddr = awaddr; p_awprot = awprot;
                p_wv = wvalid; p_wdata = wdata; p_wstrb = wstrb;
                p_bready = bready; p_arv = arvalid; p_araddr = araddr;
                p_arprot = arprot; p_rready = rready;
            end
        end
    end

    task automatic set_cfg(input int aw, input int w, input int b,
                           input int ar, input int r);
        cfg_aw_dly = aw; cfg_w_dly = w; cfg_b_dly = b;
        cfg_ar_dly = ar; cfg_r_dly = r;
        cfg_w_after_aw = 0; cfg_ar_never = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    endtask

    // Starts and ends just after a falling edge; returns one cycle after acceptance.
    task automatic send_cmd(input bit wr, input logic [5:0] a, input logic [31:0] d);
        int n;
        cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            errors++; checks++;
            $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            errors++; checks++;
            $display("FAIL rsp_wait: rsp_valid=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic take_rsp(output logic [31:0] rd, output logic er);
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic do_txn(input bit wr, input logic [5:0] a, input logic [31:0] d,
                          input int hold, output logic [31:0] rd, output logic er);
        int n;
        send_cmd(wr, a, d);
        wait_rsp(n);
        repeat (hold) @(negedge clk);
        take_rsp(rd, er);
    endtask

    task automatic test_reset;
        logic [39:0] v;
        rst = 1;
        @(negedge clk);
        v = {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_err, rsp_rdata};
        checks++;
        if (v !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", v);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_cmd_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_aw_first;
        int n;
        logic [31:0] rd;
        logic er;
        set_cfg(0, 1, 0, 0, 0);
        send_cmd(1, 6'h04, 32'h0000_1000);
        checks++;
        if ({awvalid, wvalid} !== 2'b11) begin
            errors++;
            $display("FAIL wr_valids_after_cmd: got %b required 11", {awvalid, wvalid});
        end
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid} !== 2'b01) begin
            errors++;
            $display("FAIL wr_aw_drops_alone: got %b required 01", {awvalid, wvalid});
        end
        wait_rsp(n);
        take_rsp(rd, er);
        checks++;
        if ({er, rd} !== 33'd0) begin
            errors++;
            $display("FAIL wr_rsp: err=%b rdata=%h required err=0 rdata=0", er, rd);
        end
        checks++;
        if (!(aw_hs_cyc < w_hs_cyc)) begin
            errors++;
            $display("FAIL wr_order: aw at %0d w at %0d, required aw first", aw_hs_cyc, w_hs_cyc);
        end
        checks++;
        if ({cap_awaddr, cap_awprot, cap_wstrb, cap_wdata} !== {6'h04, 3'd0, 4'hF, 32'h1000}) begin
            errors++;
            $display("FAIL wr_bus_fields: addr=%h prot=%h strb=%h data=%h required 04 0 f 00001000",
                     cap_awaddr, cap_awprot, cap_wstrb, cap_wdata);
        end
        model_mem[1] = 32'h0000_1000;
    endtask

    task automatic test_read_delay;
        logic [31:0] rd;
        logic er;
        set_cfg(0, 0, 0, 0, 3);
        s_mem[3] = 32'h0000_0080;
        model_mem[3] = 32'h0000_0080;
        do_txn(0, 6'h0C, 32'h0, 0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, model_mem[3]}) begin
            errors++;
            $display("FAIL rd_delay: err=%b rdata=%h required err=0 rdata=%h", er, rd, model_mem[3]);
        end
        checks++;
        if ({cap_araddr, cap_arprot} !== {6'h0C, 3'd0}) begin
            errors++;
            $display("FAIL rd_bus_fields: addr=%h prot=%h required 0c 0", cap_araddr, cap_arprot);
        end
    endtask

    task automatic test_write_latency;
        int n, lat;
        logic [5:0] a;
        logic [31:0] d, rd;
        logic er;
        set_cfg(0, 0, 0, 0, 0);
        a = 6'h20;
        d = $urandom();
        send_cmd(1, a, d);
        @(negedge clk);
        checks++;
        if ({bready, awvalid, wvalid} !== 3'b100) begin
            errors++;
            $display("FAIL wr_resp_next: bready/awv/wv=%b required 100", {bready, awvalid, wvalid});
        end
        wait_rsp(n);
        lat = 2 + n;
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL wr_latency: got %0d cycles required 3", lat);
        end
        take_rsp(rd, er);
        model_mem[a[5:2]] = d;
        checks++;
        if ({er, rd} !== 33'd0) begin
            errors++;
            $display("FAIL wr_fast_rsp: err=%b rdata=%h required 0 0", er, rd);
        end
    endtask

    task automatic test_rsp_backpressure;
        int n;
        logic [31:0] rd;
        logic er;
        set_cfg(1, 0, 1, 2, 1);
        send_cmd(0, 6'h04, 32'h0);
        wait_rsp(n);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, cmd_ready, rsp_rdata} !== {2'b10, model_mem[1]}) begin
                errors++;
                $display("FAIL rsp_hold[%0d]: valid=%b cmd_ready=%b rdata=%h required 1 0 %h",
                         i, rsp_valid, cmd_ready, rsp_rdata, model_mem[1]);
            end
        end
        take_rsp(rd, er);
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, d;
        logic er;
        set_cfg(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            d = $urandom();
            do_txn(1, 6'(8 + 4 * i), d, 0, rd, er);
            model_mem[2 + i] = d;
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b required 1", i, cmd_ready);
            end
        end
        do_txn(0, 6'h0C, 32'h0, 0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, model_mem[3]}) begin
            errors++;
            $display("FAIL b2b_read: err=%b rdata=%h required 0 %h", er, rd, model_mem[3]);
        end
    endtask

    task automatic test_timeout;
        int n;
        logic [31:0] rd;
        logic er;
        set_cfg(0, 0, 0, 0, 0);
        cfg_ar_never = 1;
        send_cmd(0, 6'h10, 32'h0);
        n = 0;
        while (arvalid && n < TO + 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== TO) begin
            errors++;
            $display("FAIL timeout_cycles: arvalid high %0d cycles required %0d", n, TO);
        end
        wait_rsp(n);
        take_rsp(rd, er);
        checks++;
        if ({er, rd} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL timeout_rsp: err=%b rdata=%h required 1 0", er, rd);
        end
        cfg_ar_never = 0;
        do_txn(0, 6'h04, 32'h0, 0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, model_mem[1]}) begin
            errors++;
            $display("FAIL timeout_recover: err=%b rdata=%h required 0 %h", er, rd, model_mem[1]);
        end
    endtask

    task automatic test_random;
        bit wr;
        int hold;
        logic [5:0] a;
        logic [31:0] d, rd, exp_rd;
        logic er, exp_er;
        for (int i = 0; i < 24; i++) begin
            set_cfg($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                    $urandom_range(3, 0), $urandom_range(3, 0));
            cfg_w_after_aw = 1'($urandom_range(1, 0));
            cfg_bresp = ($urandom_range(4, 0) == 0) ? 2'b10 : 2'b00;
            cfg_rresp = ($urandom_range(4, 0) == 0) ? 2'b11 : 2'b00;
            wr = 1'($urandom_range(1, 0));
            a = 6'($urandom());
            d = $urandom();
            hold = $urandom_range(2, 0);
            do_txn(wr, a, d, hold, rd, er);
            if (wr) begin
                exp_rd = 32'd0;
                exp_er = (cfg_bresp != 2'b00);
                if (!exp_er) model_mem[a[5:2]] = d;
                checks++;
                if ({cap_awaddr, cap_wdata} !== {a, d}) begin
                    errors++;
                    $display("FAIL rnd_wr_bus[%0d]: addr=%h data=%h required %h %h",
                             i, cap_awaddr, cap_wdata, a, d);
                end
            end else begin
                exp_rd = model_mem[a[5:2]];
                exp_er = (cfg_rresp != 2'b00);
            end
            checks++;
            if ({er, rd} !== {exp_er, exp_rd}) begin
                errors++;
                $display("FAIL rnd_rsp[%0d]: wr=%b err=%b rdata=%h required err=%b rdata=%h",
                         i, wr, er, rd, exp_er, exp_rd);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        bit saw_rsp;
        logic [39:0] v;
        logic [31:0] rd;
        logic er;
        set_cfg(0, 0, 0, 0, 8);
        send_cmd(0, 6'h0C, 32'h0);
        n = 0;
        while (!rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reach_rd_data: rready=%b required 1", rready);
        end
        #2 rst = 1;
        #1;
        v = {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_err, rsp_rdata};
        checks++;
        if (v !== 40'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h required 0", v);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        saw_rsp = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            saw_rsp |= rsp_valid;
        end
        checks++;
        if ({saw_rsp, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_after: saw_rsp=%b cmd_ready=%b required 0 1", saw_rsp, cmd_ready);
        end
        set_cfg(0, 0, 0, 0, 1);
        do_txn(0, 6'h08, 32'h0, 0, rd, er);
        checks++;
        if ({er, rd} !== {1'b0, model_mem[2]}) begin
            errors++;
            $display("FAIL rstmid_recover: err=%b rdata=%h required 0 %h", er, rd, model_mem[2]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 0;
        set_cfg(0, 0, 0, 0, 0);
        test_reset;
        test_write_aw_first;
        test_read_delay;
        test_write_latency;
        test_rsp_backpressure;
        test_back_to_back;
        test_timeout;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_cfg_master.md
AXIL_CFG_MASTER -- requirements
Module: axil_cfg_master

Interface
REQ-001 Parameter TIMEOUT, default 256: maximum cycles from the first VALID on an AXI channel to its response before the transaction is aborted.
REQ-002 clk  in  1  single clock; all logic is sampled on the rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-005 cmd_wr  in  1  1 = register write, 0 = register read.
REQ-006 cmd_addr  in  6  byte address; bits [5:2] select the register word.
REQ-007 cmd_wdata  in  32  write data.
REQ-008 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-009 rsp_rdata  out  32  read data; 0 for writes and for aborted transactions.
REQ-010 rsp_err  out  1  set when xRESP != 0 or the transaction timed out.
REQ-011 M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, M_AXI_AWADDR out 6, M_AXI_AWPROT out 3: write-address channel.
REQ-012 M_AXI_WVALID out 1, M_AXI_WREADY in 1, M_AXI_WDATA out 32, M_AXI_WSTRB out 4: write-data channel.
REQ-013 M_AXI_BVALID in 1, M_AXI_BREADY out 1, M_AXI_BRESP in 2: write-response channel.
REQ-014 M_AXI_ARVALID out 1, M_AXI_ARREADY in 1, M_AXI_ARADDR out 6, M_AXI_ARPROT out 3: read-address channel.
REQ-015 M_AXI_RVALID in 1, M_AXI_RREADY out 1, M_AXI_RDATA in 32, M_AXI_RRESP in 2: read-data channel.

Function
REQ-016 The block SHALL use an FSM with states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP, and SHALL keep exactly one transaction outstanding.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command handshake latches cmd_addr, cmd_wdata and cmd_wr, and the FSM moves to WR_REQ or RD_REQ.
REQ-018 AWVALID and WVALID SHALL both assert in the cycle after the command handshake; outputs are registered and there is no combinational path from command inputs to AXI outputs.
REQ-019 In WR_REQ, AWVALID and WVALID SHALL each drop independently in the cycle after their own handshake; WR_REQ exits to WR_RESP once both handshakes are done, same cycle or different cycles.
REQ-020 The master SHALL tolerate a slave that raises WREADY only after the AW handshake, and SHALL hold WVALID and WDATA stable until WREADY.
REQ-021 BREADY SHALL be 1 only in WR_RESP; on a B handshake the FSM moves to RSP with rsp_err = (BRESP != 0).
REQ-022 In RD_REQ, ARVALID SHALL hold until ARREADY, then the FSM moves to RD_DATA; RREADY SHALL be 1 only in RD_DATA; an R handshake captures RDATA into rsp_rdata with rsp_err = (RRESP != 0).
REQ-023 rsp_valid SHALL assert the cycle after the B or R handshake and hold, with data stable, until rsp_ready; the FSM then returns to IDLE, so back-to-back command acceptance is possible the following cycle.
REQ-024 AWPROT and ARPROT SHALL be 0, and WSTRB SHALL be 4'hF.
REQ-025 A timeout counter SHALL clear on command acceptance and increment in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
REQ-026 When the timeout counter reaches TIMEOUT-1, the block SHALL drop all VALID/READY outputs, go to RSP with rsp_err=1 and rsp_rdata=0, and ignore later B/R beats of that transaction.
REQ-027 BVALID or RVALID arriving outside WR_RESP or RD_DATA SHALL be ignored (READY stays 0).
REQ-028 A timeout and a handshake in the same cycle SHALL resolve in favour of the handshake.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE and all VALID/READY outputs, rsp_rdata, rsp_err and the timeout counter SHALL become 0, immediately and regardless of clk.
REQ-030 A reset during a transaction SHALL abandon it without producing a response.

Structure
REQ-031 FSM state encodings, response codes (OKAY=2'b00) and the default TIMEOUT SHALL live in a shared package.
REQ-032 The timeout counter SHALL be a sub-module named axil_timeout_cnt with clear, enable and expire ports.

Verification
REQ-033 Write 0x0000_1000 to addr 0x04; slave sets AWREADY=1 and WREADY one cycle later -> AW handshake before W, one B beat, rsp_err=0, rsp_rdata=0.
REQ-034 Read addr 0x0C; slave returns RDATA=0x0000_0080 with RRESP=0 after 3 cycles -> rsp_rdata=0x0000_0080, rsp_err=0.
REQ-035 Write with AWREADY and WREADY both high in the same cycle -> WR_RESP entered next cycle, and the total command-to-rsp_valid latency is 3 cycles when BVALID is immediate.
REQ-036 Slave never asserts ARREADY -> ARVALID drops after 256 cycles, rsp_err=1, rsp_rdata=0, and a following command is accepted.
REQ-037 rsp_ready held low for 10 cycles -> rsp_valid and rsp_rdata stable and cmd_ready=0 throughout.
REQ-038 Assert rst during RD_DATA -> all outputs 0 immediately, no rsp_valid, and cmd_ready=1 after release.
